regfile_port_ctrl: RTL and testbench

Port controller at the bitline end of the register-file bit-cell array. It takes two read requests and one write request per cycle, registers them, and decodes them into one-hot per-row `WriteEnable`/`ReadEnable1`/`ReadEnable2` strobes plus the shared `D` bus. It senses the two bitline buses and returns registered read data with valid flags. Same-cycle write-to-read forwarding and a hardwired-zero register 0 are implemented here, not in the cells.

---
 rtl/regfile_port_ctrl.sv | 135 +++++++++++++
 tb/tb_regfile_port_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_ctrl.sv
// Port controller at the bitline end of the register-file array: registers two
// read requests and one write, decodes per-row strobes, and returns registered read data.
module regfile_port_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_req1,
  input  logic                rd_req2,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   cell_d,
  output logic [NUM_REGS-1:0] cell_we,
  output logic [NUM_REGS-1:0] cell_re1,
  output logic [NUM_REGS-1:0] cell_re2,
  input  logic [DATA_W-1:0]   bitline1,
  input  logic [DATA_W-1:0]   bitline2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  output logic                rd_valid1,
  output logic                rd_valid2,
  output logic                addr_err
);

  // One extra bit so NUM_REGS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < NumRegsW;
  endfunction

  // Stage A: request registers
  logic                a_rd_req1_q, a_rd_req2_q, a_wr_req_q;
  logic [ADDR_W-1:0]   a_rd_addr1_q, a_rd_addr2_q, a_wr_addr_q;
  logic [DATA_W-1:0]   a_wr_data_q;

  // Stage C: result registers
  logic                rd_valid1_q, rd_valid2_q, addr_err_q;
  logic [DATA_W-1:0]   rd_data1_q, rd_data2_q;
  logic [DATA_W-1:0]   rd_data1_d, rd_data2_d;
  logic                addr_err_d;

  logic rd1_live, rd2_live, wr_live;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its sources, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rd_req1_q  <= 1'b0;
      a_rd_req2_q  <= 1'b0;
      a_wr_req_q   <= 1'b0;
      a_rd_addr1_q <= '0;
      a_rd_addr2_q <= '0;
      a_wr_addr_q  <= '0;
      a_wr_data_q  <= '0;
    end else begin
      a_rd_req1_q  <= rd_req1;
      a_rd_req2_q  <= rd_req2;
      a_wr_req_q   <= wr_req;
      a_rd_addr1_q <= rd_addr1;
      a_rd_addr2_q <= rd_addr2;
      a_wr_addr_q  <= wr_addr;
      a_wr_data_q  <= wr_data;
    end
  end

  // Row 0 and out-of-range rows are never touched in the array.
  assign rd1_live = a_rd_req1_q && (a_rd_addr1_q != '0) && in_range(a_rd_addr1_q);
  assign rd2_live = a_rd_req2_q && (a_rd_addr2_q != '0) && in_range(a_rd_addr2_q);
  assign wr_live  = a_wr_req_q  && (a_wr_addr_q  != '0) && in_range(a_wr_addr_q);

  // Stage B decode is purely combinational from stage A, so the enables fall
  // as soon as reset clears the A registers.
  always_comb begin
    cell_we  = '0;
    cell_re1 = '0;
    cell_re2 = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (wr_live  && (a_wr_addr_q  == ADDR_W'(r))) cell_we[r]  = 1'b1;
      if (rd1_live && (a_rd_addr1_q == ADDR_W'(r))) cell_re1[r] = 1'b1;
      if (rd2_live && (a_rd_addr2_q == ADDR_W'(r))) cell_re2[r] = 1'b1;
    end
  end

  assign cell_d = a_wr_req_q ? a_wr_data_q : '0;

  // NOTE: each next-state value gets a default first so no path through the
  // block leaves it unassigned, which would infer a latch.
  always_comb begin
    rd_data1_d = rd_data1_q;
    rd_data2_d = rd_data2_q;
    if (a_rd_req1_q) begin
      if (!rd1_live)                                  rd_data1_d = '0;
      else if (wr_live && a_wr_addr_q == a_rd_addr1_q) rd_data1_d = a_wr_data_q;
      else                                            rd_data1_d = bitline1;
    end
    if (a_rd_req2_q) begin
      if (!rd2_live)                                  rd_data2_d = '0;
      else if (wr_live && a_wr_addr_q == a_rd_addr2_q) rd_data2_d = a_wr_data_q;
      else                                            rd_data2_d = bitline2;
    end
    addr_err_d = addr_err_q
               | (a_rd_req1_q && !in_range(a_rd_addr1_q))
               | (a_rd_req2_q && !in_range(a_rd_addr2_q))
               | (a_wr_req_q  && !in_range(a_wr_addr_q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid1_q <= 1'b0;
      rd_valid2_q <= 1'b0;
      rd_data1_q  <= '0;
      rd_data2_q  <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      rd_valid1_q <= a_rd_req1_q;
      rd_valid2_q <= a_rd_req2_q;
      rd_data1_q  <= rd_data1_d;
      rd_data2_q  <= rd_data2_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign rd_valid1 = rd_valid1_q;
  assign rd_valid2 = rd_valid2_q;
  assign rd_data1  = rd_data1_q;
  assign rd_data2  = rd_data2_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: a behavioural register-file model predicts every
// strobe and read result; a simple cell array drives the bitlines from the strobes.
module tb_regfile_port_ctrl;

  localparam int NR = 24;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk, rst;
  logic          rd_req1, rd_req2, wr_req;
  logic [AW-1:0] rd_addr1, rd_addr2, wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] cell_d;
  logic [NR-1:0] cell_we, cell_re1, cell_re2;
  wire  [DW-1:0] bitline1, bitline2;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          rd_valid1, rd_valid2, addr_err;

  regfile_port_ctrl #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .rd_req1(rd_req1), .rd_req2(rd_req2),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .cell_d(cell_d), .cell_we(cell_we), .cell_re1(cell_re1), .cell_re2(cell_re2),
    .bitline1(bitline1), .bitline2(bitline2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_valid1(rd_valid1), .rd_valid2(rd_valid2), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell array: captures D on the enabled row, floats the bitline when idle.
  logic [DW-1:0] cells [NR] = '{default: '0};
  logic [DW-1:0] sel1, sel2;

  always @(posedge clk)
    for (int r = 0; r < NR; r++) if (cell_we[r]) cells[r] <= cell_d;

  always_comb begin
    sel1 = '0;
    sel2 = '0;
    for (int r = 0; r < NR; r++) begin
      if (cell_re1[r]) sel1 = cells[r];
      if (cell_re2[r]) sel2 = cells[r];
    end
  end

  assign bitline1 = (|cell_re1) ? sel1 : 'z;
  assign bitline2 = (|cell_re2) ? sel2 : 'z;

  // Reference model
  typedef struct packed {
    logic          v1;
    logic [DW-1:0] d1;
    logic          v2;
    logic [DW-1:0] d2;
    logic          err;
  } exp_t;

  logic [DW-1:0] ref_mem [NR];
  exp_t          prev;
  logic [DW-1:0] held1, held2;
  logic          model_err;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a, input logic w_ok,
                                             input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (a == 0 || int'(a) >= NR) return '0;
    if (w_ok && wa == a)         return wd;
    return ref_mem[a];
  endfunction

  task automatic reset_model();
    prev      = '0;
    held1     = '0;
    held2     = '0;
    model_err = 1'b0;
  endtask

  // Drives one request cycle, then compares stage B for this request and
  // stage C for the previous one.
  task automatic step(input logic r1, input logic [AW-1:0] a1,
                      input logic r2, input logic [AW-1:0] a2,
                      input logic w,  input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    exp_t          cur;
    logic          w_ok;
    logic [NR-1:0] e_we, e_re1, e_re2;
    logic [DW-1:0] e_d;
    rd_req1 = r1; rd_addr1 = a1;
    rd_req2 = r2; rd_addr2 = a2;
    wr_req  = w;  wr_addr  = wa; wr_data = wd;
    w_ok  = w && wa != 0 && int'(wa) < NR;
    e_we  = '0; e_re1 = '0; e_re2 = '0;
    if (w_ok) e_we[wa] = 1'b1;
    if (r1 && a1 != 0 && int'(a1) < NR) e_re1[a1] = 1'b1;
    if (r2 && a2 != 0 && int'(a2) < NR) e_re2[a2] = 1'b1;
    e_d = w ? wd : '0;
    if (r1) held1 = ref_read(a1, w_ok, wa, wd);
    if (r2) held2 = ref_read(a2, w_ok, wa, wd);
    if ((r1 && int'(a1) >= NR) || (r2 && int'(a2) >= NR) || (w && int'(wa) >= NR))
      model_err = 1'b1;
    cur = '{v1: r1, d1: held1, v2: r2, d2: held2, err: model_err};
    if (w_ok) ref_mem[wa] = wd;
    @(negedge clk);
    checks++; if (cell_we !== e_we)   begin errors++; $display("FAIL cell_we: got %h exp %h", cell_we, e_we); end
    checks++; if (cell_re1 !== e_re1) begin errors++; $display("FAIL cell_re1: got %h exp %h", cell_re1, e_re1); end
    checks++; if (cell_re2 !== e_re2) begin errors++; $display("FAIL cell_re2: got %h exp %h", cell_re2, e_re2); end
    checks++; if (cell_d !== e_d)     begin errors++; $display("FAIL cell_d: got %h exp %h", cell_d, e_d); end
    checks++; if (rd_valid1 !== prev.v1) begin errors++; $display("FAIL rd_valid1: got %b exp %b", rd_valid1, prev.v1); end
    checks++; if (rd_valid2 !== prev.v2) begin errors++; $display("FAIL rd_valid2: got %b exp %b", rd_valid2, prev.v2); end
    checks++; if (rd_data1 !== prev.d1)  begin errors++; $display("FAIL rd_data1: got %h exp %h", rd_data1, prev.d1); end
    checks++; if (rd_data2 !== prev.d2)  begin errors++; $display("FAIL rd_data2: got %h exp %h", rd_data2, prev.d2); end
    checks++; if (addr_err !== prev.err) begin errors++; $display("FAIL addr_err: got %b exp %b", addr_err, prev.err); end
    checks++; if ($isunknown({rd_data1, rd_data2})) begin errors++; $display("FAIL rd_data_known: got %h_%h exp no X/Z", rd_data1, rd_data2); end
    prev = cur;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rd_req1 = 0; rd_req2 = 0; wr_req = 0;
    rd_addr1 = 0; rd_addr2 = 0; wr_addr = 0; wr_data = 0;
    for (int r = 0; r < NR; r++) ref_mem[r] = '0;
    reset_model();
    repeat (2) @(negedge clk);
    checks++;
    if ({cell_we, cell_re1, cell_re2, cell_d, rd_data1, rd_data2, rd_valid1, rd_valid2, addr_err} !== '0) begin
      errors++; $display("FAIL reset_outputs: got we=%h d=%h v=%b%b err=%b exp all zero", cell_we, cell_d, rd_valid1, rd_valid2, addr_err);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic_write_read();
    logic [NR-1:0] oh = '0;
    oh[5] = 1'b1;
    step(0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
    checks++; if (cell_we !== oh) begin errors++; $display("FAIL basic_we_onehot: got %h exp %h", cell_we, oh); end
    step(1, 5, 0, 0, 0, 0, 0);
    checks++; if (cell_we !== '0) begin errors++; $display("FAIL basic_we_one_cycle: got %h exp 0", cell_we); end
    idle();
    checks++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_read: got v=%b d=%h exp v=1 d=deadbeef", rd_valid1, rd_data1);
    end
  endtask

  task automatic test_forwarding();
    step(0, 0, 0, 0, 1, 7, 32'h11);
    idle();
    step(1, 7, 1, 7, 1, 7, 32'h22);
    step(1, 7, 0, 0, 0, 0, 0);
    checks++; if (rd_data1 !== 32'h22 || rd_data2 !== 32'h22) begin
      errors++; $display("FAIL forward_same_edge: got %h/%h exp 22/22", rd_data1, rd_data2);
    end
    idle();
    checks++; if (rd_data1 !== 32'h22) begin errors++; $display("FAIL forward_next_edge: got %h exp 22", rd_data1); end
  endtask

  task automatic test_read_before_write();
    step(1, 5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5, 32'h1234);
    checks++; if (rd_data1 !== 32'hDEADBEEF) begin errors++; $display("FAIL read_old_data: got %h exp deadbeef", rd_data1); end
    step(1, 5, 0, 0, 0, 0, 0);
    idle();
    checks++; if (rd_data1 !== 32'h1234) begin errors++; $display("FAIL read_new_data: got %h exp 1234", rd_data1); end
  endtask

  task automatic test_reg0();
    step(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
    checks++; if (cell_we !== '0) begin errors++; $display("FAIL reg0_we: got %h exp 0", cell_we); end
    step(0, 0, 1, 0, 0, 0, 0);
    checks++; if (cell_re2 !== '0) begin errors++; $display("FAIL reg0_re2: got %h exp 0", cell_re2); end
    idle();
    checks++; if (rd_valid2 !== 1'b1 || rd_data2 !== '0) begin
      errors++; $display("FAIL reg0_read: got v=%b d=%h exp v=1 d=0", rd_valid2, rd_data2);
    end
  endtask

  task automatic test_dual_read();
    logic [NR-1:0] oh3 = '0;
    logic [NR-1:0] oh4 = '0;
    oh3[3] = 1'b1;
    oh4[4] = 1'b1;
    step(0, 0, 0, 0, 1, 3, 32'hA);
    step(0, 0, 0, 0, 1, 4, 32'hB);
    step(1, 3, 1, 4, 0, 0, 0);
    checks++; if (cell_re1 !== oh3 || cell_re2 !== oh4) begin
      errors++; $display("FAIL dual_enables: got %h/%h exp %h/%h", cell_re1, cell_re2, oh3, oh4);
    end
    idle();
    checks++; if (rd_data1 !== 32'hA || rd_data2 !== 32'hB) begin
      errors++; $display("FAIL dual_data: got %h/%h exp a/b", rd_data1, rd_data2);
    end
  endtask

  task automatic test_out_of_range();
    step(1, 30, 0, 0, 0, 0, 0);
    checks++; if (cell_re1 !== '0) begin errors++; $display("FAIL oor_re1: got %h exp 0", cell_re1); end
    idle();
    checks++; if (rd_valid1 !== 1'b1 || rd_data1 !== '0 || addr_err !== 1'b1) begin
      errors++; $display("FAIL oor_read: got v=%b d=%h err=%b exp v=1 d=0 err=1", rd_valid1, rd_data1, addr_err);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL oor_sticky: got %b exp 1", addr_err); end
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++)
      step(1'($urandom), AW'($urandom_range(0, 31)), 1'($urandom), AW'($urandom_range(0, 31)),
           1'($urandom), AW'($urandom_range(0, 31)), $urandom);
  endtask

  task automatic test_reset_mid_op();
    logic [NR-1:0] oh9 = '0;
    oh9[9] = 1'b1;
    step(0, 0, 0, 0, 1, 9, 32'h99);
    idle();
    idle();
    rd_req1 = 0; rd_req2 = 0;
    wr_req = 1; wr_addr = 9; wr_data = 32'h5A5A5A5A;
    @(posedge clk);
    #2;
    checks++; if (cell_we !== oh9) begin errors++; $display("FAIL midrst_we_before: got %h exp %h", cell_we, oh9); end
    rst = 1'b0;
    #1;
    checks++;
    if ({cell_we, cell_re1, cell_re2, cell_d, rd_data1, rd_data2, rd_valid1, rd_valid2, addr_err} !== '0) begin
      errors++; $display("FAIL midrst_outputs: got we=%h d=%h v=%b%b err=%b exp all zero", cell_we, cell_d, rd_valid1, rd_valid2, addr_err);
    end
    wr_req = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    reset_model();
    idle();
    idle();
    step(1, 9, 0, 0, 0, 0, 0);
    idle();
    checks++; if (rd_data1 !== 32'h99) begin errors++; $display("FAIL midrst_r9_kept: got %h exp 99", rd_data1); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_write_read();
    test_forwarding();
    test_read_before_write();
    test_reg0();
    test_dual_read();
    test_out_of_range();
    test_random(400);
    test_reset_mid_op();
    test_random(60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
